// File: rtl/latch_enable_sequencer_pkg.sv
// Shared definitions for the latch enable sequencer: FSM state encoding and
// helper functions used to size the phase counter and vet the parameters.
package latch_enable_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    PULSE = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_e;

  // Longest of the three timed phases.
  function automatic int max_phase(input int setup_cyc, input int pulse_cyc, input int hold_cyc);
    int m;
    m = setup_cyc;
    if (pulse_cyc > m) m = pulse_cyc;
    if (hold_cyc > m) m = hold_cyc;
    return m;
  endfunction

  // The phase counter is loaded with (length - 1), so clog2(max) bits hold
  // every reload value without wrapping.
  function automatic int phase_cnt_width(input int setup_cyc, input int pulse_cyc, input int hold_cyc);
    int m;
    m = max_phase(setup_cyc, pulse_cyc, hold_cyc);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

  // Every timed phase must last at least one cycle.
  function automatic bit timing_params_ok(input int setup_cyc, input int pulse_cyc, input int hold_cyc);
    return (setup_cyc >= 1) && (pulse_cyc >= 1) && (hold_cyc >= 1);
  endfunction

  // Supported size of the latch bank.
  function automatic bit latch_count_ok(input int n_latch);
    return (n_latch >= 2) && (n_latch <= 16);
  endfunction

endpackage

// File: rtl/latch_enable_sequencer_phase_counter.sv
// Loadable down-counter with a zero flag. One instance times the setup,
// pulse and hold phases; the owner muxes the reload value per phase.
module latch_enable_sequencer_phase_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Load has priority; decrement saturates at zero so a phase never wraps.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/latch_enable_sequencer.sv
// Drives a bank of D latches sharing one data line: accepts a write request,
// presents the data, then pulses exactly one latch enable framed by setup and
// hold windows. All outputs are registered; at most one enable is ever high.
module latch_enable_sequencer
  import latch_enable_sequencer_pkg::*;
#(
  parameter int N_LATCH   = 4,
  parameter int DATA_W    = 1,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [$clog2(N_LATCH)-1:0] req_sel,
  input  logic [DATA_W-1:0]          req_data,
  output logic [DATA_W-1:0]          d_out,
  output logic [N_LATCH-1:0]         en_out,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  localparam int SEL_W = $clog2(N_LATCH);
  localparam int CNT_W = phase_cnt_width(SETUP_CYC, PULSE_CYC, HOLD_CYC);
  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYC - 1);

  // Reject unusable parameter sets while elaborating.
  if (!timing_params_ok(SETUP_CYC, PULSE_CYC, HOLD_CYC)) begin : g_bad_timing
    $error("latch_enable_sequencer: SETUP_CYC, PULSE_CYC and HOLD_CYC must all be >= 1");
  end
  if (!latch_count_ok(N_LATCH)) begin : g_bad_latch_count
    $error("latch_enable_sequencer: N_LATCH must be in 2..16");
  end

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [N_LATCH-1:0] en_q, en_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               cnt_load;
  logic [CNT_W-1:0]   cnt_load_val;
  logic               cnt_dec;
  logic               cnt_zero;

  logic               sel_in_range;
  logic [N_LATCH-1:0] sel_onehot;

  // A select at or above N_LATCH is only possible for non-power-of-two banks.
  assign sel_in_range = ({1'b0, sel_q} < (SEL_W + 1)'(N_LATCH));

  // One-hot decode of the captured select; an out-of-range select decodes to zero.
  for (genvar gi = 0; gi < N_LATCH; gi++) begin : g_decode
    assign sel_onehot[gi] = (sel_q == SEL_W'(gi));
  end

  latch_enable_sequencer_phase_counter #(
    .CNT_W (CNT_W)
  ) u_phase_counter (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  // Next-state logic; each phase reloads the counter for the following one.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    data_d       = data_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid && ready_q) begin
          sel_d        = req_sel;
          data_d       = req_data;
          cnt_load     = 1'b1;
          cnt_load_val = SETUP_LOAD;
          state_d      = SETUP;
        end
      end
      SETUP: begin
        if (cnt_zero) begin
          if (sel_in_range) begin
            cnt_load     = 1'b1;
            cnt_load_val = PULSE_LOAD;
            state_d      = PULSE;
          end else begin
            state_d = DONE;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      PULSE: begin
        if (cnt_zero) begin
          cnt_load     = 1'b1;
          cnt_load_val = HOLD_LOAD;
          state_d      = HOLD;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      HOLD: begin
        if (cnt_zero) begin
          state_d = DONE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are derived from the next state so they register in step with it.
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
    err_d   = (state_d == DONE) && !sel_in_range;
    en_d    = (state_d == PULSE) ? sel_onehot : '0;
  end

  // State and output registers; reset drops enables immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      data_q  <= '0;
      en_q    <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      en_q    <= en_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign req_ready = ready_q;
  assign d_out     = data_q;
  assign en_out    = en_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_latch_enable_sequencer.sv
// Scoreboard bench for latch_enable_sequencer. Three instances cover the
// default timing, a 3-latch bank (out-of-range select) and a stretched
// SETUP=3/PULSE=1/HOLD=4 timing. Each accepted request pushes its expected
// timeline; a per-cycle monitor compares the DUT against it.
module tb_latch_enable_sequencer;

  localparam int NUM_DUT = 3;

  function automatic int cfg_n(input int d);
    return (d == 1) ? 3 : 4;
  endfunction
  function automatic int cfg_s(input int d);
    return (d == 2) ? 3 : 1;
  endfunction
  function automatic int cfg_p(input int d);
    return (d == 2) ? 1 : 2;
  endfunction
  function automatic int cfg_h(input int d);
    return (d == 2) ? 4 : 1;
  endfunction

  logic       clk = 1'b0;
  logic       rst_n     [NUM_DUT];
  logic       req_valid [NUM_DUT];
  logic       req_ready [NUM_DUT];
  logic [1:0] req_sel   [NUM_DUT];
  logic       req_data  [NUM_DUT];
  logic       d_out     [NUM_DUT];
  logic [3:0] en_w      [NUM_DUT];
  logic       busy      [NUM_DUT];
  logic       done      [NUM_DUT];
  logic       err       [NUM_DUT];

  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   post_rst  [NUM_DUT];
  logic d_prev    [NUM_DUT];
  logic last_data [NUM_DUT];

  typedef struct {
    int dut;
    int t_acc;
    int sel;
    int data;
    bit err;
    int en_start;
    int en_end;
    int done_cyc;
  } txn_t;

  txn_t sb_q[$];

  for (genvar gi = 0; gi < NUM_DUT; gi++) begin : g_dut
    localparam int NL = cfg_n(gi);
    logic [NL-1:0] en_loc;
    latch_enable_sequencer #(
      .N_LATCH   (NL),
      .DATA_W    (1),
      .SETUP_CYC (cfg_s(gi)),
      .PULSE_CYC (cfg_p(gi)),
      .HOLD_CYC  (cfg_h(gi))
    ) u_dut (
      .clk       (clk),
      .reset_n   (rst_n[gi]),
      .req_valid (req_valid[gi]),
      .req_ready (req_ready[gi]),
      .req_sel   (req_sel[gi]),
      .req_data  (req_data[gi]),
      .d_out     (d_out[gi]),
      .en_out    (en_loc),
      .busy      (busy[gi]),
      .done      (done[gi]),
      .err       (err[gi])
    );
    assign en_w[gi] = 4'(en_loc);
  end

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int d = 0; d < NUM_DUT; d++) begin
      post_rst[d] <= rst_n[d] ? post_rst[d] + 1 : 0;
    end
  end

  task automatic check_value(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  function automatic bit outstanding(input int d);
    for (int k = 0; k < sb_q.size(); k++) begin
      if (sb_q[k].dut == d) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Per-cycle comparison of one DUT against the scoreboard. c is the cycle
  // number in "value seen just before edge c" terms, so acceptance at edge T
  // is observed at c == T.
  task automatic monitor_dut(input int d);
    int         c;
    int         idx;
    txn_t       t;
    logic [3:0] en_exp;
    c   = cyc + 1;
    idx = -1;
    for (int k = 0; k < sb_q.size(); k++) begin
      if (sb_q[k].dut == d && idx < 0) idx = k;
    end
    check_value($sformatf("dut%0d_onehot", d), 32'($countones(en_w[d]) <= 1), 32'd1);
    if (en_w[d] != 4'd0) check_value($sformatf("dut%0d_d_stable", d), 32'(d_out[d]), 32'(d_prev[d]));
    if (!rst_n[d]) begin
      if (idx >= 0) sb_q.delete(idx);
      last_data[d] = 1'b0;
      check_value($sformatf("dut%0d_rst_en", d), 32'(en_w[d]), 32'd0);
      check_value($sformatf("dut%0d_rst_done", d), 32'(done[d]), 32'd0);
      check_value($sformatf("dut%0d_rst_busy", d), 32'(busy[d]), 32'd0);
      check_value($sformatf("dut%0d_rst_ready", d), 32'(req_ready[d]), 32'd0);
    end else if (idx >= 0) begin
      t = sb_q[idx];
      en_exp = (!t.err && c >= t.en_start && c <= t.en_end) ? 4'(1 << t.sel) : 4'd0;
      check_value($sformatf("dut%0d_en", d), 32'(en_w[d]), 32'(en_exp));
      check_value($sformatf("dut%0d_d_out", d), 32'(d_out[d]), 32'(t.data));
      check_value($sformatf("dut%0d_busy", d), 32'(busy[d]), 32'd1);
      check_value($sformatf("dut%0d_ready", d), 32'(req_ready[d]), 32'd0);
      check_value($sformatf("dut%0d_done", d), 32'(done[d]), 32'(c == t.done_cyc));
      check_value($sformatf("dut%0d_err", d), 32'(err[d]), 32'(c == t.done_cyc && t.err));
      if (c == t.done_cyc) begin
        $display("dut%0d txn sel=%0d data=%0d err=%0d accepted=%0d done=%0d",
                 d, t.sel, t.data, t.err, t.t_acc, c);
        last_data[d] = t.data[0];
        sb_q.delete(idx);
      end
    end else begin
      check_value($sformatf("dut%0d_idle_en", d), 32'(en_w[d]), 32'd0);
      check_value($sformatf("dut%0d_idle_done", d), 32'(done[d]), 32'd0);
      check_value($sformatf("dut%0d_idle_err", d), 32'(err[d]), 32'd0);
      check_value($sformatf("dut%0d_idle_busy", d), 32'(busy[d]), 32'd0);
      check_value($sformatf("dut%0d_idle_ready", d), 32'(req_ready[d]), 32'(post_rst[d] > 0));
      check_value($sformatf("dut%0d_idle_d_out", d), 32'(d_out[d]), 32'(last_data[d]));
      if (req_valid[d] && req_ready[d]) begin
        t.dut      = d;
        t.t_acc    = c;
        t.sel      = int'(req_sel[d]);
        t.data     = int'(req_data[d]);
        t.err      = (t.sel >= cfg_n(d));
        t.en_start = c + 1 + cfg_s(d);
        t.en_end   = t.en_start + cfg_p(d) - 1;
        t.done_cyc = t.err ? (c + 1 + cfg_s(d)) : (c + 1 + cfg_s(d) + cfg_p(d) + cfg_h(d));
        sb_q.push_back(t);
      end
    end
    d_prev[d] = d_out[d];
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < NUM_DUT; d++) monitor_dut(d);
  end

  // Present a request and wait (bounded) for it to be accepted; returns the
  // acceptance edge number. Inputs are scrambled afterwards unless the
  // request line is to stay asserted for a following request.
  task automatic send_req(input int d, input int sel, input int data, input bit keep_valid, output int t_acc);
    bit ok;
    req_valid[d] = 1'b1;
    req_sel[d]   = 2'(sel);
    req_data[d]  = data[0];
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (rst_n[d] && req_ready[d]) ok = 1'b1;
    end
    check_value($sformatf("dut%0d_accepted", d), 32'(ok), 32'd1);
    @(posedge clk);
    #1;
    t_acc = cyc;
    if (!keep_valid) begin
      req_valid[d] = 1'b0;
      req_sel[d]   = ~req_sel[d];
      req_data[d]  = ~req_data[d];
    end
  endtask

  task automatic wait_idle(input int d);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (!outstanding(d) && !busy[d]) ok = 1'b1;
    end
    check_value($sformatf("dut%0d_idle_reached", d), 32'(ok), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int  t1;
    int  t2;
    bit  seen;
    for (int d = 0; d < NUM_DUT; d++) begin
      rst_n[d]     = 1'b0;
      req_valid[d] = 1'b0;
      req_sel[d]   = 2'd0;
      req_data[d]  = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_value("reset_en", 32'(en_w[0]), 32'd0);
    check_value("reset_d_out", 32'(d_out[0]), 32'd0);
    check_value("reset_ready", 32'(req_ready[0]), 32'd0);
    check_value("reset_busy", 32'(busy[0]), 32'd0);
    @(posedge clk);
    #1;
    for (int d = 0; d < NUM_DUT; d++) rst_n[d] = 1'b1;
    @(posedge clk);
    #1;
    check_value("ready_after_release", 32'(req_ready[0]), 32'd1);

    // Basic write: sel=2, data=1 on the default timing.
    send_req(0, 2, 1, 1'b0, t1);
    wait_idle(0);

    // Back-to-back with req_valid held: sel=0 then sel=3.
    send_req(0, 0, 1, 1'b1, t1);
    send_req(0, 3, 0, 1'b0, t2);
    check_value("b2b_spacing", 32'(t2 - t1), 32'd6);
    wait_idle(0);

    // Out-of-range select on the 3-latch bank, then a normal write.
    send_req(1, 3, 1, 1'b0, t1);
    wait_idle(1);
    send_req(1, 1, 0, 1'b0, t1);
    wait_idle(1);

    // Stretched timing: SETUP=3, PULSE=1, HOLD=4.
    send_req(2, 2, 1, 1'b0, t1);
    wait_idle(2);
    send_req(2, 0, 0, 1'b0, t1);
    wait_idle(2);

    // Reset while en_out == 4'b0010: enable must clear without a clock edge.
    send_req(0, 1, 1, 1'b0, t1);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (en_w[0] == 4'b0010) seen = 1'b1;
    end
    check_value("pulse_seen_before_reset", 32'(seen), 32'd1);
    #2;
    rst_n[0] = 1'b0;
    #1;
    check_value("async_reset_en", 32'(en_w[0]), 32'd0);
    check_value("async_reset_done", 32'(done[0]), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n[0] = 1'b1;
    @(negedge clk);
    check_value("release_no_done", 32'(done[0]), 32'd0);
    @(posedge clk);
    #1;
    check_value("release_ready", 32'(req_ready[0]), 32'd1);

    // Normal operation resumes after the aborted transaction.
    send_req(0, 3, 0, 1'b0, t1);
    wait_idle(0);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
